// File: rtl/gba_audio_pkg.sv
// Shared types and constants for the GBA Direct Sound FIFO scheduler.
package gba_audio_pkg;

  typedef enum logic [1:0] {
    DS_EMPTY,
    DS_FETCH,
    DS_HOLD
  } ds_state_t;

  localparam int   DS_SEL_A_BIT = 10;
  localparam int   DS_SEL_B_BIT = 14;
  localparam logic DS_CH_A      = 1'b0;
  localparam logic DS_CH_B      = 1'b1;

endpackage

// File: rtl/ds_chan_seq.sv
// One Direct Sound channel: pops a FIFO word, plays its 4 bytes on ticks,
// and raises a DMA refill request when the FIFO runs low.
module ds_chan_seq
  import gba_audio_pkg::*;
#(
  parameter int REQ_THRESH = 4,
  parameter int SIZE_W     = 4
) (
  input  logic              gba_clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              seq_rst,
  input  logic              ack,
  input  logic [SIZE_W-1:0] fifo_size,
  input  logic [31:0]       fifo_val,
  output logic              fifo_re,
  output logic              fifo_clr,
  output logic [7:0]        sample,
  output logic              strobe,
  output logic              pending,
  output logic              underrun
);

  localparam logic [SIZE_W-1:0] THRESH = SIZE_W'(REQ_THRESH);

  ds_state_t   state, state_nxt;
  logic [31:0] word;
  logic [1:0]  byte_idx;
  logic        popped;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge gba_clk) begin
    if (reset) state <= DS_EMPTY;
    else       state <= state_nxt;
  end

  // NOTE: defaulting state_nxt first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    if (seq_rst) begin
      state_nxt = DS_EMPTY;
    end else begin
      unique case (state)
        DS_EMPTY: if (fifo_re) state_nxt = DS_FETCH;
        DS_FETCH: state_nxt = DS_HOLD;
        DS_HOLD:  if (tick && byte_idx == 2'd3) state_nxt = DS_EMPTY;
        default:  state_nxt = DS_EMPTY;
      endcase
    end
  end

  // A pop is suppressed while a clear is in flight so a cleared FIFO is never read.
  always_comb begin
    fifo_re  = (state == DS_EMPTY) && (fifo_size != '0) && !seq_rst && !fifo_clr && !reset;
    underrun = tick && !seq_rst && (state != DS_HOLD);
  end

  always_ff @(posedge gba_clk) begin
    if (reset) begin
      word     <= '0;
      byte_idx <= '0;
      sample   <= '0;
      strobe   <= 1'b0;
      fifo_clr <= 1'b0;
      pending  <= 1'b0;
      popped   <= 1'b0;
    end else begin
      strobe   <= 1'b0;
      fifo_clr <= 1'b0;
      popped   <= fifo_re;
      if (seq_rst) begin
        byte_idx <= '0;
        sample   <= '0;
        fifo_clr <= 1'b1;
        pending  <= 1'b1;
      end else begin
        if (state == DS_FETCH) begin
          word     <= fifo_val;
          byte_idx <= '0;
        end
        if (state == DS_HOLD && tick) begin
          sample   <= word[{byte_idx, 3'b000} +: 8];
          strobe   <= 1'b1;
          byte_idx <= byte_idx + 2'd1;
        end
        // fifo_size already reflects the pop one cycle after fifo_re; a new need beats an ack.
        if (popped && fifo_size <= THRESH) pending <= 1'b1;
        else if (ack)                      pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gba_ds_fifo_sched.sv
// Direct Sound A/B sequencer with a round-robin sound-DMA arbiter.
// Optional feature: GBA_DS_UNDERRUN_STATS_EN adds saturating dropped-tick counters.
module gba_ds_fifo_sched
  import gba_audio_pkg::*;
#(
  parameter int REQ_THRESH = 4,
  parameter int FIFO_WORDS = 8
) (
  input  logic                               gba_clk,
  input  logic                               reset,
  input  logic                               tm0_ovf,
  input  logic                               tm1_ovf,
  input  logic [15:0]                        sound_cnt_h,
  input  logic                               seq_rst_a,
  input  logic                               seq_rst_b,
  input  logic [$clog2(FIFO_WORDS+1)-1:0]    fifo_size_a,
  input  logic [31:0]                        fifo_val_a,
  output logic                               fifo_re_a,
  output logic                               fifo_clr_a,
  input  logic [$clog2(FIFO_WORDS+1)-1:0]    fifo_size_b,
  input  logic [31:0]                        fifo_val_b,
  output logic                               fifo_re_b,
  output logic                               fifo_clr_b,
  output logic [7:0]                         sample_a,
  output logic [7:0]                         sample_b,
  output logic                               strobe_a,
  output logic                               strobe_b,
  output logic                               dma_req,
  output logic                               dma_ch,
  input  logic                               dma_ack
`ifdef GBA_DS_UNDERRUN_STATS_EN
  ,
  output logic [15:0]                        underrun_cnt_a,
  output logic [15:0]                        underrun_cnt_b
`endif
);

  localparam int SIZE_W = $clog2(FIFO_WORDS + 1);

  logic tick_a, tick_b, ack_a, ack_b;
  logic pending_a, pending_b, underrun_a, underrun_b;
  logic grant, lock_q, ch_q, rr_last;

  assign tick_a = sound_cnt_h[DS_SEL_A_BIT] ? tm1_ovf : tm0_ovf;
  assign tick_b = sound_cnt_h[DS_SEL_B_BIT] ? tm1_ovf : tm0_ovf;

  // Once a request is visible its channel is locked until the DMA acknowledges it.
  assign dma_req = pending_a | pending_b;
  assign grant   = (pending_a & pending_b) ? ~rr_last : pending_b;
  assign dma_ch  = lock_q ? ch_q : grant;
  assign ack_a   = dma_ack & dma_req & (dma_ch == DS_CH_A);
  assign ack_b   = dma_ack & dma_req & (dma_ch == DS_CH_B);

  always_ff @(posedge gba_clk) begin
    if (reset) begin
      lock_q  <= 1'b0;
      ch_q    <= DS_CH_A;
      rr_last <= DS_CH_B;
    end else if (dma_req && dma_ack) begin
      lock_q  <= 1'b0;
      rr_last <= dma_ch;
    end else if (dma_req) begin
      lock_q  <= 1'b1;
      ch_q    <= dma_ch;
    end
  end

  ds_chan_seq #(.REQ_THRESH(REQ_THRESH), .SIZE_W(SIZE_W)) u_chan_a (
    .gba_clk   (gba_clk),
    .reset     (reset),
    .tick      (tick_a),
    .seq_rst   (seq_rst_a),
    .ack       (ack_a),
    .fifo_size (fifo_size_a),
    .fifo_val  (fifo_val_a),
    .fifo_re   (fifo_re_a),
    .fifo_clr  (fifo_clr_a),
    .sample    (sample_a),
    .strobe    (strobe_a),
    .pending   (pending_a),
    .underrun  (underrun_a)
  );

  ds_chan_seq #(.REQ_THRESH(REQ_THRESH), .SIZE_W(SIZE_W)) u_chan_b (
    .gba_clk   (gba_clk),
    .reset     (reset),
    .tick      (tick_b),
    .seq_rst   (seq_rst_b),
    .ack       (ack_b),
    .fifo_size (fifo_size_b),
    .fifo_val  (fifo_val_b),
    .fifo_re   (fifo_re_b),
    .fifo_clr  (fifo_clr_b),
    .sample    (sample_b),
    .strobe    (strobe_b),
    .pending   (pending_b),
    .underrun  (underrun_b)
  );

  // Only the two timer-select bits matter here; the rest belongs to the mixer.
  logic unused_cnt_h;
  assign unused_cnt_h = ^sound_cnt_h;

`ifdef GBA_DS_UNDERRUN_STATS_EN
  always_ff @(posedge gba_clk) begin
    if (reset || seq_rst_a)
      underrun_cnt_a <= '0;
    else if (underrun_a && underrun_cnt_a != 16'hFFFF)
      underrun_cnt_a <= underrun_cnt_a + 16'd1;
    if (reset || seq_rst_b)
      underrun_cnt_b <= '0;
    else if (underrun_b && underrun_cnt_b != 16'hFFFF)
      underrun_cnt_b <= underrun_cnt_b + 16'd1;
  end
`else
  logic unused_underrun;
  assign unused_underrun = underrun_a | underrun_b;
`endif

endmodule
